enemy_squad: RTL and testbench

Parametrised pool of enemy units for the lane game logic; the next generation of the single-unit enemy FSM. It holds up to NUM_UNITS independent enemies, each with its own health, power, position and death countdown. Enemies deploy from a type code, advance on game ticks, take damage addressed by slot, and report an attack value, breach and kill events to the top-level game controller.

---
 rtl/enemy_squad_pkg.sv | 18 +
 rtl/enemy_squad_slot.sv | 109 ++++++++++
 rtl/enemy_squad.sv | 117 +++++++++++
 tb/tb_enemy_squad.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_squad_pkg.sv
// Shared definitions for the enemy squad: slot state encoding and the
// per-type power table.
package enemy_squad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ALIVE = 3'b010,
    ST_DYING = 3'b100
  } slot_state_t;

  localparam int TYPE_W = 2;

  // Power doubles with each type step: 16, 32, 64, 128.
  function automatic logic [7:0] type_power(input logic [TYPE_W-1:0] t);
    return 8'd16 << t;
  endfunction

endpackage

// File: rtl/enemy_squad_slot.sv
// One enemy unit: lifecycle FSM plus health, power, position and death timer.
// Lethal damage takes priority over movement in the same cycle.
module enemy_squad_slot
  import enemy_squad_pkg::*;
#(
  parameter int POS_W       = 9,
  parameter int HP_W        = 8,
  parameter int MAX_POS     = 320,
  parameter int DEAD_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_deploy,
  input  logic [TYPE_W-1:0] i_type,
  input  logic              i_hit,
  input  logic [HP_W-1:0]   i_dmg_amount,
  input  logic              i_move,
  output logic              o_idle,
  output logic              o_alive,
  output logic [POS_W-1:0]  o_pos,
  output logic [HP_W-1:0]   o_power,
  output logic              o_lethal,
  output logic              o_breach
);

  localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

  slot_state_t      r_state, w_state;
  logic [HP_W-1:0]  r_hp, w_hp;
  logic [HP_W-1:0]  r_power, w_power;
  logic [POS_W-1:0] r_pos, w_pos;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             w_lethal, w_breach;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hp    <= '0;
      r_power <= '0;
      r_pos   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_hp    <= w_hp;
      r_power <= w_power;
      r_pos   <= w_pos;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_hp     = r_hp;
    w_power  = r_power;
    w_pos    = r_pos;
    w_cnt    = r_cnt;
    w_lethal = 1'b0;
    w_breach = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_deploy) begin
          w_state = ST_ALIVE;
          w_hp    = '1;
          w_power = HP_W'(type_power(i_type));
          w_pos   = '0;
          w_cnt   = '0;
        end
      end
      ST_ALIVE: begin
        if (i_hit && (i_dmg_amount >= r_hp)) begin
          w_lethal = 1'b1;
          w_state  = ST_DYING;
          w_hp     = '0;
          w_cnt    = '0;
        end else begin
          if (i_hit) w_hp = r_hp - i_dmg_amount;
          // Reaching the base frees the slot at once; it is not a kill.
          if (i_move) begin
            if (r_pos == POS_W'(MAX_POS - 1)) begin
              w_state  = ST_IDLE;
              w_pos    = '0;
              w_breach = 1'b1;
            end else begin
              w_pos = r_pos + 1'b1;
            end
          end
        end
      end
      ST_DYING: begin
        if (r_cnt == CNT_W'(DEAD_CYCLES - 1)) begin
          w_state = ST_IDLE;
          w_pos   = '0;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign o_idle   = (r_state == ST_IDLE);
  assign o_alive  = (r_state == ST_ALIVE);
  assign o_pos    = r_pos;
  assign o_power  = r_power;
  assign o_lethal = w_lethal;
  assign o_breach = w_breach;

endmodule

// File: rtl/enemy_squad.sv
// Pool of enemy slots: free-slot allocation, frontmost-unit attack selection,
// breach/kill pulse merging and the saturating kill counter.
module enemy_squad
  import enemy_squad_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int POS_W       = 9,
  parameter int HP_W        = 8,
  parameter int MAX_POS     = 320,
  parameter int DEAD_CYCLES = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_tick,
  input  logic                       i_move_en,
  input  logic                       i_deploy_valid,
  input  logic [1:0]                 i_deploy_type,
  output logic                       o_deploy_ready,
  input  logic                       i_dmg_valid,
  input  logic [2:0]                 i_dmg_slot,
  input  logic [HP_W-1:0]            i_dmg_amount,
  output logic [NUM_UNITS*POS_W-1:0] o_pos_bus,
  output logic [NUM_UNITS-1:0]       o_alive,
  output logic [HP_W-1:0]            o_attack_out,
  output logic                       o_breach,
  output logic                       o_kill_pulse,
  output logic [7:0]                 o_kill_count
);

  logic [NUM_UNITS-1:0] w_idle, w_alive, w_lethal, w_breach, w_deploy_sel;
  logic [POS_W-1:0]     w_pos   [NUM_UNITS];
  logic [HP_W-1:0]      w_power [NUM_UNITS];
  logic [HP_W-1:0]      w_best_pow;
  logic [POS_W-1:0]     w_best_pos;
  logic                 w_any;
  logic [3:0]           w_kills;
  logic [8:0]           w_kc_sum;

  logic [HP_W-1:0] r_attack;
  logic            r_breach, r_kill;
  logic [7:0]      r_kill_count;

  genvar g;
  generate
    for (g = 0; g < NUM_UNITS; g++) begin : g_slot
      enemy_squad_slot #(
        .POS_W(POS_W), .HP_W(HP_W), .MAX_POS(MAX_POS), .DEAD_CYCLES(DEAD_CYCLES)
      ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .i_deploy    (i_deploy_valid & w_deploy_sel[g]),
        .i_type      (i_deploy_type),
        .i_hit       (i_dmg_valid && (i_dmg_slot == 3'(g))),
        .i_dmg_amount(i_dmg_amount),
        .i_move      (i_tick & i_move_en),
        .o_idle      (w_idle[g]),
        .o_alive     (w_alive[g]),
        .o_pos       (w_pos[g]),
        .o_power     (w_power[g]),
        .o_lethal    (w_lethal[g]),
        .o_breach    (w_breach[g])
      );
      assign o_pos_bus[g*POS_W +: POS_W] = w_pos[g];
    end
  endgenerate

  always_comb begin
    w_deploy_sel = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (w_idle[i]) w_deploy_sel = NUM_UNITS'(1) << i;
    end
  end

  // Frontmost live unit attacks; strict compare keeps the lowest index on ties.
  always_comb begin
    w_best_pow = '0;
    w_best_pos = '0;
    w_any      = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_alive[i] && !w_lethal[i] && (!w_any || (w_pos[i] > w_best_pos))) begin
        w_any      = 1'b1;
        w_best_pos = w_pos[i];
        w_best_pow = w_power[i];
      end
    end
  end

  always_comb begin
    w_kills = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_kills = w_kills + {3'b000, w_lethal[i]};
    end
    w_kc_sum = {1'b0, r_kill_count} + {5'b00000, w_kills};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_attack     <= '0;
      r_breach     <= 1'b0;
      r_kill       <= 1'b0;
      r_kill_count <= '0;
    end else begin
      r_attack     <= (i_tick && !i_move_en) ? w_best_pow : '0;
      r_breach     <= |w_breach;
      r_kill       <= |w_lethal;
      r_kill_count <= w_kc_sum[8] ? 8'hFF : w_kc_sum[7:0];
    end
  end

  assign o_deploy_ready = |w_idle;
  assign o_alive        = w_alive;
  assign o_attack_out   = r_attack;
  assign o_breach       = r_breach;
  assign o_kill_pulse   = r_kill;
  assign o_kill_count   = r_kill_count;

endmodule

// File: tb/tb_enemy_squad.sv
// Self-checking bench for enemy_squad: directed scenarios plus a randomized
// run against a per-slot behavioural model of the game rules.
module tb_enemy_squad;

  localparam int NUM   = 4;
  localparam int PW    = 9;
  localparam int HW    = 8;
  localparam int MAXP  = 8;
  localparam int DEAD  = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tick = 0, move_en = 0, dep_v = 0, dmg_v = 0;
  logic [1:0]      dep_t = 0;
  logic [2:0]      dmg_s = 0;
  logic [HW-1:0]   dmg_a = 0;
  logic            ready;
  logic [NUM*PW-1:0] pos_bus;
  logic [NUM-1:0]  alive;
  logic [HW-1:0]   attack;
  logic            breach, kpulse;
  logic [7:0]      kcount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  enemy_squad #(
    .NUM_UNITS(NUM), .POS_W(PW), .HP_W(HW), .MAX_POS(MAXP), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .reset(reset), .i_tick(tick), .i_move_en(move_en),
    .i_deploy_valid(dep_v), .i_deploy_type(dep_t), .o_deploy_ready(ready),
    .i_dmg_valid(dmg_v), .i_dmg_slot(dmg_s), .i_dmg_amount(dmg_a),
    .o_pos_bus(pos_bus), .o_alive(alive), .o_attack_out(attack),
    .o_breach(breach), .o_kill_pulse(kpulse), .o_kill_count(kcount)
  );

  // Model: 0 = idle, 1 = alive, 2 = dying
  int m_st[NUM], m_hp[NUM], m_pw[NUM], m_pos[NUM], m_cnt[NUM];
  int m_atk, m_br, m_kp, m_kc;

  task automatic model_reset();
    for (int s = 0; s < NUM; s++) begin
      m_st[s] = 0; m_hp[s] = 0; m_pw[s] = 0; m_pos[s] = 0; m_cnt[s] = 0;
    end
    m_atk = 0; m_br = 0; m_kp = 0; m_kc = 0;
  endtask

  function automatic logic [NUM-1:0] m_alive();
    logic [NUM-1:0] v = '0;
    for (int s = 0; s < NUM; s++) v[s] = (m_st[s] == 1);
    return v;
  endfunction

  function automatic logic [NUM*PW-1:0] m_posbus();
    logic [NUM*PW-1:0] v = '0;
    for (int s = 0; s < NUM; s++) v[s*PW +: PW] = PW'(m_pos[s]);
    return v;
  endfunction

  function automatic logic m_ready();
    logic r = 1'b0;
    for (int s = 0; s < NUM; s++) if (m_st[s] == 0) r = 1'b1;
    return r;
  endfunction

  task automatic model_step(input bit tk, mv, dv, input int dt, input bit hv,
                            input int hs, input int ha);
    int tgt = -1, best = -1, kills = 0, br = 0, st;
    bit lethal[NUM];
    for (int s = 0; s < NUM; s++) if (m_st[s] == 0 && tgt < 0) tgt = s;
    for (int s = 0; s < NUM; s++)
      lethal[s] = hv && (hs == s) && (m_st[s] == 1) && (ha >= m_hp[s]);
    if (tk && !mv)
      for (int s = 0; s < NUM; s++)
        if (m_st[s] == 1 && !lethal[s] && (best < 0 || m_pos[s] > m_pos[best])) best = s;
    for (int s = 0; s < NUM; s++) begin
      st = m_st[s];
      if (st == 1) begin
        if (lethal[s]) begin
          m_st[s] = 2; m_hp[s] = 0; m_cnt[s] = 0; kills++;
        end else begin
          if (hv && hs == s) m_hp[s] -= ha;
          if (tk && mv) begin
            m_pos[s]++;
            if (m_pos[s] == MAXP) begin m_st[s] = 0; m_pos[s] = 0; br = 1; end
          end
        end
      end else if (st == 2) begin
        if (m_cnt[s] == DEAD - 1) begin m_st[s] = 0; m_pos[s] = 0; m_cnt[s] = 0; end
        else m_cnt[s]++;
      end else if (dv && s == tgt) begin
        m_st[s] = 1; m_hp[s] = 255; m_pw[s] = 16 << dt; m_pos[s] = 0;
      end
    end
    m_atk = (best >= 0) ? m_pw[best] : 0;
    m_br  = br;
    m_kp  = (kills > 0);
    m_kc  = (m_kc + kills > 255) ? 255 : m_kc + kills;
  endtask

  task automatic cycle(input bit tk, mv, dv, input int dt, input bit hv,
                       input int hs, input int ha);
    tick = tk; move_en = mv; dep_v = dv; dep_t = 2'(dt);
    dmg_v = hv; dmg_s = 3'(hs); dmg_a = HW'(ha);
    model_step(tk, mv, dv, dt, hv, hs, ha);
    @(posedge clk); #1;
    tick = 0; move_en = 0; dep_v = 0; dmg_v = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; tick = 0; move_en = 0; dep_v = 0; dmg_v = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alive !== '0) begin failures++; $display("FAIL reset_alive got=%b want=0", alive); end
    checks++; if (pos_bus !== '0) begin failures++; $display("FAIL reset_pos got=%h want=0", pos_bus); end
    checks++; if (attack !== '0 || breach !== 0 || kpulse !== 0) begin
      failures++; $display("FAIL reset_pulses atk=%0d br=%b kp=%b want 0", attack, breach, kpulse); end
    checks++; if (kcount !== 8'd0) begin failures++; $display("FAIL reset_kc got=%0d want=0", kcount); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
  endtask

  task automatic test_deploy();
    do_reset();
    cycle(0, 0, 1, 2, 0, 0, 0);
    checks++; if (alive !== 4'b0001) begin failures++; $display("FAIL deploy_first got=%b want=0001", alive); end
    checks++; if (pos_bus !== '0) begin failures++; $display("FAIL deploy_pos got=%h want=0", pos_bus); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL deploy_ready1 got=%b want=1", ready); end
    cycle(1, 0, 0, 0, 0, 0, 0);
    checks++; if (attack !== 8'd64) begin failures++; $display("FAIL deploy_power got=%0d want=64", attack); end
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, k, 0, 0, 0);
    checks++; if (alive !== 4'b1111 || ready !== 1'b0) begin
      failures++; $display("FAIL deploy_full alive=%b ready=%b want 1111/0", alive, ready); end
    cycle(0, 0, 1, 3, 0, 0, 0);
    checks++; if (alive !== 4'b1111 || ready !== 1'b0) begin
      failures++; $display("FAIL deploy_fifth alive=%b ready=%b want 1111/0", alive, ready); end
  endtask

  task automatic test_damage();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 100);
    checks++; if (kpulse !== 1'b0 || alive !== 4'b1111) begin
      failures++; $display("FAIL dmg_nonlethal kp=%b alive=%b want 0/1111", kpulse, alive); end
    cycle(0, 0, 0, 0, 1, 0, 155);
    checks++; if (kpulse !== 1'b1 || kcount !== 8'd1 || alive !== 4'b1110) begin
      failures++; $display("FAIL dmg_lethal kp=%b kc=%0d alive=%b want 1/1/1110", kpulse, kcount, alive); end
    for (int k = 1; k <= DEAD; k++) begin
      idle();
      checks++; if (ready !== (k == DEAD)) begin
        failures++; $display("FAIL dying_hold cyc=%0d ready=%b want=%b", k, ready, k == DEAD); end
    end
    checks++; if (kpulse !== 1'b0) begin failures++; $display("FAIL dmg_pulse_once got=%b want=0", kpulse); end
    cycle(0, 0, 1, 1, 0, 0, 0);
    checks++; if (alive !== 4'b1111) begin failures++; $display("FAIL dmg_reuse got=%b want=1111", alive); end
  endtask

  task automatic test_attack();
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, 0);
    repeat (5) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 0, 0, 0);
    checks++; if (pos_bus[PW-1:0] !== 9'd5 || alive !== 4'b0011) begin
      failures++; $display("FAIL attack_setup pos0=%0d alive=%b want 5/0011", pos_bus[PW-1:0], alive); end
    cycle(1, 0, 0, 0, 0, 0, 0);
    checks++; if (attack !== 8'd16) begin failures++; $display("FAIL attack_front got=%0d want=16", attack); end
    idle();
    checks++; if (attack !== 8'd0) begin failures++; $display("FAIL attack_oneshot got=%0d want=0", attack); end
  endtask

  task automatic test_breach();
    do_reset();
    cycle(0, 0, 1, 1, 0, 0, 0);
    repeat (MAXP - 1) cycle(1, 1, 0, 0, 0, 0, 0);
    checks++; if (pos_bus[PW-1:0] !== 9'(MAXP - 1) || breach !== 1'b0) begin
      failures++; $display("FAIL breach_pre pos=%0d br=%b want %0d/0", pos_bus[PW-1:0], breach, MAXP - 1); end
    cycle(1, 1, 0, 0, 0, 0, 0);
    checks++; if (breach !== 1'b1 || alive !== 4'b0000 || pos_bus !== '0 || kcount !== 8'd0) begin
      failures++; $display("FAIL breach br=%b alive=%b pos=%h kc=%0d want 1/0/0/0", breach, alive, pos_bus, kcount); end
    idle();
    checks++; if (breach !== 1'b0) begin failures++; $display("FAIL breach_oneshot got=%b want=0", breach); end
  endtask

  task automatic test_collision();
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, 0);
    repeat (MAXP - 1) cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 0, 255);
    checks++; if (kpulse !== 1'b1 || breach !== 1'b0 || kcount !== 8'd1) begin
      failures++; $display("FAIL collide_kill kp=%b br=%b kc=%0d want 1/0/1", kpulse, breach, kcount); end
    checks++; if (pos_bus[PW-1:0] !== 9'(MAXP - 1) || alive !== 4'b0000) begin
      failures++; $display("FAIL collide_pos pos=%0d alive=%b want %0d/0", pos_bus[PW-1:0], alive, MAXP - 1); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cycle(0, 0, 1, 2, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 255);
    repeat (4) idle();
    checks++; if (kcount !== 8'd1 || alive !== 4'b0010) begin
      failures++; $display("FAIL midrst_pre kc=%0d alive=%b want 1/0010", kcount, alive); end
    #2 reset = 1;
    #1;
    checks++; if (alive !== '0 || pos_bus !== '0 || kcount !== 8'd0 || attack !== '0 ||
                  breach !== 0 || kpulse !== 0 || ready !== 1'b1) begin
      failures++; $display("FAIL midrst alive=%b pos=%h kc=%0d atk=%0d ready=%b want all 0, ready 1",
                           alive, pos_bus, kcount, attack, ready); end
    model_reset();
    @(negedge clk) reset = 0;
  endtask

  task automatic test_random();
    bit tk, mv, dv, hv;
    int dt, hs, ha;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      dv = ($urandom % 3) == 0;
      dt = $urandom % 4;
      tk = ($urandom % 2) == 0;
      mv = ($urandom % 3) != 0;
      hv = ($urandom % 3) == 0;
      hs = $urandom % 8;
      ha = (($urandom % 4) == 0) ? ($urandom % 256) : ($urandom % 48);
      cycle(tk, mv, dv, dt, hv, hs, ha);
      checks++; if (alive !== m_alive() || pos_bus !== m_posbus() || ready !== m_ready()) begin
        failures++; $display("FAIL rand_state n=%0d alive=%b/%b pos=%h/%h ready=%b/%b",
                             n, alive, m_alive(), pos_bus, m_posbus(), ready, m_ready()); end
      checks++; if (attack !== HW'(m_atk) || breach !== m_br[0] || kpulse !== m_kp[0] ||
                    kcount !== 8'(m_kc)) begin
        failures++; $display("FAIL rand_out n=%0d atk=%0d/%0d br=%b/%0d kp=%b/%0d kc=%0d/%0d",
                             n, attack, m_atk, breach, m_br, kpulse, m_kp, kcount, m_kc); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_deploy();
    test_damage();
    test_attack();
    test_breach();
    test_collision();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
